bsg_wormhole_mem_responder: RTL and testbench
=============================================

// Module: bsg_wormhole_mem_responder
// PURPOSE
// - Far-end responder for the wormhole memory link: sinks request packets arriving over the SDR wormhole link.
// - Executes each request against a local flop/SRAM array and returns one response packet to the requester's cord, echoing the cid.
// - Serves as the bring-up and loopback target for the chip noc mem link, and as the endpoint model in system benches.
// PARAMETERS
// - flit_width_p  64  wormhole flit width; must be >= header field sum
// - len_width_p   4   packet length field width, in body flits
// - cid_width_p   4   concentrator id field width
// - cord_width_p  8   cord field width
// - els_p         256 memory words of flit_width_p; power of 2
// - addr_width_lp `BSG_SAFE_CLOG2(els_p), derived
// PORTS
// - clk_i            in   1             single clock
// - reset_n_i        in   1             asynchronous, active-low reset
// - my_cord_i        in   cord_width_p  own cord, placed in src_cord of responses; static
// - link_v_i         in   1             request flit valid
// - link_data_i      in   flit_width_p  request flit
// - link_ready_and_o out  1             request flit accepted when v & ready_and
// - link_v_o         out  1             response flit valid
// - link_data_o      out  flit_width_p  response flit
// - link_ready_and_i in   1             downstream ready; flit transfers on v & ready_and
// BEHAVIOUR
// - Header, LSB first: cord, len, cid, src_cord, op[1:0], addr[addr_width_lp]; upper bits 0 on tx, ignored on rx.
// - Ops: 0=READ, 1=WRITE, 2/3 reserved. Response op: 0=RDATA, 1=WACK, 2=ERR.
// - Reset, while reset_n_i=0 and the first cycle after:
//   - state=IDLE, link_v_o=0, link_ready_and_o=0, link_data_o=0.
//   - Array contents not reset.
// - Handshake rules:
//   - link_ready_and_o=1 only in IDLE and RECV; 0 in all send states, so rx and tx never handshake together.
//   - link_v_o is never withdrawn once raised; link_data_o is held stable until the handshake.
// - IDLE: header handshake latches len/cid/src_cord/op/addr.
//   - len!=0: go to RECV.
//   - len==0: go to RESP_HDR.
// - RECV: each body-flit handshake decrements remaining len.
//   - WRITE: flit written to mem[addr], then addr <= addr+1 mod els_p (wraps).
//   - READ or reserved: body flit discarded.
//   - Last flit (remaining==1): go to RESP_HDR next cycle.
// - RESP_HDR: link_v_o=1; header = {cord=src_cord, cid, src_cord=my_cord_i, op, len}.
//   - op and len: READ -> RDATA, len=1; WRITE -> WACK, len=0; reserved -> ERR, len=0.
//   - READ issues the array read at the start addr on entry; the read must not use any address advanced in RECV.
//   - On handshake: RDATA -> RESP_DATA; otherwise -> IDLE.
// - RESP_DATA: link_v_o=1, link_data_o=mem[start addr]; handshake -> IDLE.
// - Latency:
//   - READ len=0: header accepted cycle N, response header valid cycle N+1, data valid the cycle after the header handshake.
//   - WRITE: ack header valid the cycle after the last body-flit handshake.
// - Back-to-back: a new header is accepted in IDLE the cycle after the final response handshake; no bubble beyond that.
// - Write wrap: addr=els_p-1 with len=2 writes els_p-1 then 0.
// - Reset mid-packet: return to IDLE; writes already done are kept; no response is sent; remaining flits of that packet are treated as a new header (the link must be reset together).
// - Read-after-write: a READ after a WACK returns the written data; no forwarding hazard, since the write completes before the ack.
// STRUCTURE
// - Shared package bsg_wormhole_mem_pkg:
//   - header struct macro, parameterised by widths;
//   - op/resp enums;
//   - state enum {eIdle, eRecv, eRespHdr, eRespData}.
// - Storage: one bsg_mem_1rw_sync instance, els_p x flit_width_p; write in RECV, read issued on entry to RESP_HDR.
// - No new sub-module; FSM, length counter and address counter live in this module.
// TESTING
// - Reset: hold reset_n_i=0 for 5 cycles with link_v_i=1 -> link_v_o=0 and link_ready_and_o=0 throughout.
// - WRITE len=3 addr=0x10, data A,B,C, then READ addr=0x11 -> WACK len=0 cid echoed, then RDATA = B to cord src.
// - WRITE len=2 addr=0xFF (els_p=256) data X,Y; READ 0xFF and READ 0x00 -> X and Y (wrap).
// - Op=3, len=2 -> both body flits consumed; ERR response len=0; no array write (READ back shows old data).
// - Backpressure: link_ready_and_i=0 for 7 cycles during RESP_DATA -> link_v_o and data held stable; no new header accepted.
// - Reset asserted after 1 of 3 write body flits -> no response; mem[addr] holds flit 1; next packet served normally.

Source files
------------

// File: rtl/bsg_wormhole_mem_pkg.sv
// Shared types for the wormhole memory link: header layout, op codes,
// response codes and the responder state encoding.

`ifndef BSG_WORMHOLE_MEM_HDR_S
`define BSG_WORMHOLE_MEM_HDR_S
// Header, LSB first: cord, len, cid, src_cord, op, addr.
`define BSG_WORMHOLE_MEM_HDR_STRUCT(addr_w, cord_w, len_w, cid_w) \
  struct packed { \
    logic [addr_w-1:0] addr; \
    logic [1:0]        op; \
    logic [cord_w-1:0] src_cord; \
    logic [cid_w-1:0]  cid; \
    logic [len_w-1:0]  len; \
    logic [cord_w-1:0] cord; \
  }
`endif

package bsg_wormhole_mem_pkg;

  typedef enum logic [1:0] {
    eOpRead   = 2'd0,
    eOpWrite  = 2'd1,
    eOpRsvd2  = 2'd2,
    eOpRsvd3  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    eRespRdata = 2'd0,
    eRespWack  = 2'd1,
    eRespErr   = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    eIdle     = 2'd0,
    eRecv     = 2'd1,
    eRespHdr  = 2'd2,
    eRespData = 2'd3
  } state_e;

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: one read or write per cycle, read data
// appears the cycle after the read and holds until the next read.

module bsg_mem_1rw_sync #(
  parameter int width_p      = 64,
  parameter int els_p        = 256,
  parameter int addr_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    v_i,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  output logic [width_p-1:0]      data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] data_q;

  // Array write, or registered read that holds between accesses.
  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      mem_q[addr_i] <= data_i;
    end else if (v_i) begin
      data_q <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_wormhole_mem_responder.sv
// Far-end wormhole memory responder: sinks one request packet, executes it
// against the local array and returns a single response packet to the
// requester's cord with the cid echoed.

module bsg_wormhole_mem_responder
  import bsg_wormhole_mem_pkg::*;
#(
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 4,
  parameter int cord_width_p = 8,
  parameter int els_p        = 256,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cord_width_p-1:0] my_cord_i,
  input  logic                    link_v_i,
  input  logic [flit_width_p-1:0] link_data_i,
  output logic                    link_ready_and_o,
  output logic                    link_v_o,
  output logic [flit_width_p-1:0] link_data_o,
  input  logic                    link_ready_and_i
);

  typedef `BSG_WORMHOLE_MEM_HDR_STRUCT(addr_width_lp, cord_width_p, len_width_p, cid_width_p) hdr_s;
  localparam int hdr_width_lp = $bits(hdr_s);

  hdr_s hdr_in;
  hdr_s resp_hdr;
  assign hdr_in = hdr_s'(link_data_i[hdr_width_lp-1:0]);

  generate
    if (flit_width_p > hdr_width_lp) begin : g_unused_hdr
      logic unused_hdr_bits;
      assign unused_hdr_bits = ^link_data_i[flit_width_p-1:hdr_width_lp];
    end
  endgenerate

  state_e                   state_q, state_d;
  logic                     rst_done_q, rst_done_d;
  logic [len_width_p-1:0]   len_q, len_d;
  logic [1:0]               op_q, op_d;
  logic [cid_width_p-1:0]   cid_q, cid_d;
  logic [cord_width_p-1:0]  src_q, src_d;
  logic [addr_width_lp-1:0] addr_q, addr_d;
  logic [addr_width_lp-1:0] addr_start_q, addr_start_d;

  logic                     mem_v, mem_w;
  logic [addr_width_lp-1:0] mem_addr;
  logic [flit_width_p-1:0]  mem_data_o;

  bsg_mem_1rw_sync #(
    .width_p      (flit_width_p),
    .els_p        (els_p),
    .addr_width_p (addr_width_lp)
  ) mem (
    .clk_i  (clk_i),
    .v_i    (mem_v),
    .w_i    (mem_w),
    .addr_i (mem_addr),
    .data_i (link_data_i),
    .data_o (mem_data_o)
  );

  // Control state; rst_done_q keeps the link quiet for one cycle after reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= eIdle;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= rst_done_d;
    end
  end

  // Packet fields and counters; only meaningful while a packet is in flight.
  always_ff @(posedge clk_i) begin
    len_q        <= len_d;
    op_q         <= op_d;
    cid_q        <= cid_d;
    src_q        <= src_d;
    addr_q       <= addr_d;
    addr_start_q <= addr_start_d;
  end

  // Next-state, link handshakes, array access and response formatting.
  always_comb begin
    state_d          = state_q;
    rst_done_d       = 1'b1;
    len_d            = len_q;
    op_d             = op_q;
    cid_d            = cid_q;
    src_d            = src_q;
    addr_d           = addr_q;
    addr_start_d     = addr_start_q;
    mem_v            = 1'b0;
    mem_w            = 1'b0;
    mem_addr         = addr_q;
    link_ready_and_o = 1'b0;
    link_v_o         = 1'b0;
    link_data_o      = '0;

    resp_hdr          = '0;
    resp_hdr.cord     = src_q;
    resp_hdr.cid      = cid_q;
    resp_hdr.src_cord = my_cord_i;
    case (op_q)
      eOpRead: begin
        resp_hdr.op  = eRespRdata;
        resp_hdr.len = len_width_p'(1);
      end
      eOpWrite: resp_hdr.op = eRespWack;
      default:  resp_hdr.op = eRespErr;
    endcase

    case (state_q)
      eIdle: begin
        link_ready_and_o = rst_done_q;
        if (link_v_i && rst_done_q) begin
          len_d        = hdr_in.len;
          op_d         = hdr_in.op;
          cid_d        = hdr_in.cid;
          src_d        = hdr_in.src_cord;
          addr_d       = hdr_in.addr;
          addr_start_d = hdr_in.addr;
          if (hdr_in.len != '0) begin
            state_d = eRecv;
          end else begin
            state_d = eRespHdr;
            // Zero-length read: launch the array read now so data is ready
            // by the time the response header goes out.
            if (hdr_in.op == eOpRead) begin
              mem_v    = 1'b1;
              mem_addr = hdr_in.addr;
            end
          end
        end
      end

      eRecv: begin
        link_ready_and_o = 1'b1;
        if (link_v_i) begin
          len_d = len_q - len_width_p'(1);
          if (op_q == eOpWrite) begin
            mem_v    = 1'b1;
            mem_w    = 1'b1;
            mem_addr = addr_q;
            addr_d   = addr_q + addr_width_lp'(1);
          end
          if (len_q == len_width_p'(1)) begin
            state_d = eRespHdr;
            // Reads always return the start address, never the walked one.
            if (op_q == eOpRead) begin
              mem_v    = 1'b1;
              mem_addr = addr_start_q;
            end
          end
        end
      end

      eRespHdr: begin
        link_v_o    = 1'b1;
        link_data_o = flit_width_p'(resp_hdr);
        if (link_ready_and_i) begin
          state_d = (op_q == eOpRead) ? eRespData : eIdle;
        end
      end

      eRespData: begin
        link_v_o    = 1'b1;
        link_data_o = mem_data_o;
        if (link_ready_and_i) begin
          state_d = eIdle;
        end
      end

      default: state_d = eIdle;
    endcase
  end

endmodule

// File: tb/tb_bsg_wormhole_mem_responder.sv
// Directed bench for the wormhole memory responder: a table of request
// packets with hand-computed responses, plus reset, backpressure and
// mid-packet reset sequences.

module tb_bsg_wormhole_mem_responder;

  logic        clk;
  logic        reset_n;
  logic [7:0]  my_cord;
  logic        link_v_i;
  logic [63:0] link_data_i;
  logic        link_ready_and_o;
  logic        link_v_o;
  logic [63:0] link_data_o;
  logic        link_ready_and_i;

  int total;
  int bad;

  localparam logic [7:0] MY_CORD = 8'h5A;

  bsg_wormhole_mem_responder #(
    .flit_width_p (64),
    .len_width_p  (4),
    .cid_width_p  (4),
    .cord_width_p (8),
    .els_p        (256)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .my_cord_i        (my_cord),
    .link_v_i         (link_v_i),
    .link_data_i      (link_data_i),
    .link_ready_and_o (link_ready_and_o),
    .link_v_o         (link_v_o),
    .link_data_o      (link_data_o),
    .link_ready_and_i (link_ready_and_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  len;
    logic [7:0]  addr;
    logic [3:0]  cid;
    logic [7:0]  src;
    logic [63:0] body [3];
    logic [1:0]  exp_op;
    logic [3:0]  exp_len;
    logic [63:0] exp_data;
  } vec_t;

  // Header, LSB first: cord[7:0] len[11:8] cid[15:12] src[23:16] op[25:24] addr[33:26].
  function automatic logic [63:0] mk_hdr(input logic [7:0] cord, input logic [3:0] len,
                                         input logic [3:0] cid, input logic [7:0] src,
                                         input logic [1:0] op, input logic [7:0] addr);
    return {30'd0, addr, op, src, cid, len, cord};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out got none expected handshake", name);
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_flit(input logic [63:0] d);
    int t;
    link_v_i    = 1'b1;
    link_data_i = d;
    t = 0;
    while (!link_ready_and_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) timeout_fail("send_flit");
    @(posedge clk); #1;
    link_v_i    = 1'b0;
    link_data_i = '0;
  endtask

  task automatic recv_flit(output logic [63:0] d);
    int t;
    link_ready_and_i = 1'b1;
    t = 0;
    while (!link_v_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) timeout_fail("recv_flit");
    d = link_data_o;
    @(posedge clk); #1;
    link_ready_and_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [63:0] got;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    send_flit(mk_hdr(8'h00, v.len, v.cid, v.src, v.op, v.addr));
    for (int i = 0; i < int'(v.len); i++) send_flit(v.body[i]);
    chk({tag, "_lat"}, {63'd0, link_v_o}, 64'd1);
    recv_flit(got);
    chk({tag, "_hdr"}, got, mk_hdr(v.src, v.exp_len, v.cid, MY_CORD, v.exp_op, 8'h00));
    if (v.exp_op == 2'd0) begin
      recv_flit(got);
      chk({tag, "_data"}, got, v.exp_data);
    end
    chk({tag, "_b2b_rdy"}, {63'd0, link_ready_and_o}, 64'd1);
  endtask

  function automatic vec_t mk_vec(input logic [1:0] op, input logic [3:0] len,
                                  input logic [7:0] addr, input logic [3:0] cid,
                                  input logic [7:0] src, input logic [63:0] b0,
                                  input logic [63:0] b1, input logic [63:0] b2,
                                  input logic [1:0] exp_op, input logic [3:0] exp_len,
                                  input logic [63:0] exp_data);
    vec_t v;
    v.op = op; v.len = len; v.addr = addr; v.cid = cid; v.src = src;
    v.body[0] = b0; v.body[1] = b1; v.body[2] = b2;
    v.exp_op = exp_op; v.exp_len = exp_len; v.exp_data = exp_data;
    return v;
  endfunction

  localparam logic [63:0] DA = 64'hAAAA_0000_1111_0001;
  localparam logic [63:0] DB = 64'hBBBB_0000_2222_0002;
  localparam logic [63:0] DC = 64'hCCCC_0000_3333_0003;
  localparam logic [63:0] DX = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] DY = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] DJ = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] DP = 64'h5050_5050_0000_0040;
  localparam logic [63:0] DQ = 64'h5151_5151_0000_0041;

  vec_t vecs [12];

  initial begin
    logic [63:0] got;
    total = 0;
    bad   = 0;
    my_cord          = MY_CORD;
    link_v_i         = 1'b1;
    link_data_i      = mk_hdr(8'h00, 4'd0, 4'd1, 8'h11, 2'd0, 8'h00);
    link_ready_and_i = 1'b0;
    reset_n          = 1'b0;

    // op, len, addr, cid, src, body0..2, exp_op, exp_len, exp_data
    vecs[0]  = mk_vec(2'd1, 4'd3, 8'h10, 4'h3, 8'h21, DA, DB, DC, 2'd1, 4'd0, 64'd0);
    vecs[1]  = mk_vec(2'd0, 4'd0, 8'h11, 4'h7, 8'h22, 0,  0,  0,  2'd0, 4'd1, DB);
    vecs[2]  = mk_vec(2'd0, 4'd0, 8'h10, 4'h1, 8'h23, 0,  0,  0,  2'd0, 4'd1, DA);
    vecs[3]  = mk_vec(2'd0, 4'd0, 8'h12, 4'hE, 8'h24, 0,  0,  0,  2'd0, 4'd1, DC);
    vecs[4]  = mk_vec(2'd1, 4'd2, 8'hFF, 4'h5, 8'h30, DX, DY, 0,  2'd1, 4'd0, 64'd0);
    vecs[5]  = mk_vec(2'd0, 4'd0, 8'hFF, 4'h6, 8'h31, 0,  0,  0,  2'd0, 4'd1, DX);
    vecs[6]  = mk_vec(2'd0, 4'd0, 8'h00, 4'h8, 8'h32, 0,  0,  0,  2'd0, 4'd1, DY);
    vecs[7]  = mk_vec(2'd3, 4'd2, 8'h10, 4'h9, 8'h40, DJ, DJ, 0,  2'd2, 4'd0, 64'd0);
    vecs[8]  = mk_vec(2'd0, 4'd0, 8'h10, 4'hA, 8'h41, 0,  0,  0,  2'd0, 4'd1, DA);
    vecs[9]  = mk_vec(2'd2, 4'd0, 8'h12, 4'hB, 8'h42, 0,  0,  0,  2'd2, 4'd0, 64'd0);
    vecs[10] = mk_vec(2'd0, 4'd2, 8'h11, 4'hC, 8'h43, DJ, DJ, 0,  2'd0, 4'd1, DB);
    vecs[11] = mk_vec(2'd0, 4'd1, 8'h12, 4'hD, 8'h44, DJ, 0,  0,  2'd0, 4'd1, DC);

    // Reset held for 5 cycles with a request being offered.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_v_o", {63'd0, link_v_o}, 64'd0);
      chk("rst_rdy", {63'd0, link_ready_and_o}, 64'd0);
      chk("rst_data", link_data_o, 64'd0);
    end
    reset_n = 1'b1;
    #1;
    chk("rst_after_rdy", {63'd0, link_ready_and_o}, 64'd0);
    link_v_i    = 1'b0;
    link_data_i = '0;
    @(posedge clk); #1;
    chk("post_rst_rdy", {63'd0, link_ready_and_o}, 64'd1);
    chk("post_rst_v_o", {63'd0, link_v_o}, 64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Backpressure on the data flit of a read.
    send_flit(mk_hdr(8'h00, 4'd0, 4'h2, 8'h50, 2'd0, 8'h10));
    recv_flit(got);
    chk("bp_hdr", got, mk_hdr(8'h50, 4'd1, 4'h2, MY_CORD, 2'd0, 8'h00));
    link_v_i    = 1'b1;
    link_data_i = mk_hdr(8'h00, 4'd0, 4'h3, 8'h51, 2'd0, 8'h11);
    for (int i = 0; i < 7; i++) begin
      chk("bp_v_o", {63'd0, link_v_o}, 64'd1);
      chk("bp_data", link_data_o, DA);
      chk("bp_rdy", {63'd0, link_ready_and_o}, 64'd0);
      @(posedge clk); #1;
    end
    link_v_i    = 1'b0;
    link_data_i = '0;
    recv_flit(got);
    chk("bp_final", got, DA);
    chk("bp_idle_v", {63'd0, link_v_o}, 64'd0);

    // Reset after the first of three write body flits.
    send_flit(mk_hdr(8'h00, 4'd3, 4'h4, 8'h60, 2'd1, 8'h40));
    send_flit(DP);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_v_o", {63'd0, link_v_o}, 64'd0);
    chk("mid_rst_rdy", {63'd0, link_ready_and_o}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_resp", {63'd0, link_v_o}, 64'd0);
      @(posedge clk); #1;
    end
    run_vec(mk_vec(2'd0, 4'd0, 8'h40, 4'h4, 8'h61, 0, 0, 0, 2'd0, 4'd1, DP), 100);
    run_vec(mk_vec(2'd1, 4'd1, 8'h41, 4'h5, 8'h62, DQ, 0, 0, 2'd1, 4'd0, 64'd0), 101);
    run_vec(mk_vec(2'd0, 4'd0, 8'h41, 4'h6, 8'h63, 0, 0, 0, 2'd0, 4'd1, DQ), 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
